// File: rtl/pe_ctrl.sv
// Sequencer for a PE array: weight preload, operand streaming, pipeline drain, completion.
// Optional busy-cycle performance counter enabled by defining PE_CTRL_PERF_EN.
module pe_ctrl #(
    parameter int ROWS     = 4,
    parameter int CNT_BW   = 16,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CNT_BW-1:0] cmd_len,
    input  logic              in_valid,
    output logic [1:0]        gemm_uno,
    output logic              wload_o,
    output logic              feed_en,
    output logic [CNT_BW-1:0] beat_idx,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_BW-1:0] perf_cyc_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [CNT_BW-1:0] len_r;
    logic [CNT_BW-1:0] beat_r;
    logic [CNT_BW-1:0] phase_r;
    logic [1:0]        uno_r;
    logic              ready_r;
    logic              accept_s;
    logic              feed_s;
    logic              wload_s;
    logic              busy_s;
    logic              done_s;
    logic              last_beat_s;

    assign accept_s    = cmd_valid & ready_r & (state_r == ST_IDLE);
    assign last_beat_s = feed_s & (beat_r == (len_r - CNT_BW'(1)));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (cmd_len == {CNT_BW{1'b0}}) begin
                        state_s = ST_DONE;
                    end else if (cmd_op == 2'b00) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_STREAM;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (phase_r == CNT_BW'(ROWS - 1)) begin
                    state_s = ST_STREAM;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_STREAM: begin
                if (last_beat_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (phase_r == CNT_BW'(PIPE_LAT - 1)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode; feed_en follows in_valid directly so a beat is taken the cycle it arrives
    always_comb begin
        wload_s = 1'b0;
        feed_s  = 1'b0;
        busy_s  = 1'b1;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE:   busy_s  = 1'b0;
            ST_LOAD:   wload_s = 1'b1;
            ST_STREAM: feed_s  = in_valid;
            ST_DRAIN:  busy_s  = 1'b1;
            ST_DONE:   done_s  = 1'b1;
            default:   busy_s  = 1'b0;
        endcase
    end

    // Phase counter for LOAD and DRAIN durations, restarted on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= {CNT_BW{1'b0}};
        end else if (state_s != state_r) begin
            phase_r <= {CNT_BW{1'b0}};
        end else begin
            phase_r <= phase_r + CNT_BW'(1);
        end
    end

    // cmd_ready held low through reset and raised by the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= (state_s == ST_IDLE);
        end
    end

    // Command latch and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uno_r  <= 2'b00;
            len_r  <= {CNT_BW{1'b0}};
            beat_r <= {CNT_BW{1'b0}};
        end else if (accept_s) begin
            uno_r  <= cmd_op;
            len_r  <= cmd_len;
            beat_r <= {CNT_BW{1'b0}};
        end else if (feed_s) begin
            beat_r <= beat_r + CNT_BW'(1);
        end
    end

`ifdef PE_CTRL_PERF_EN
    logic [CNT_BW-1:0] cyc_r;
    logic [CNT_BW-1:0] perf_r;
    logic [CNT_BW-1:0] cyc_inc_s;

    assign cyc_inc_s = (&cyc_r) ? cyc_r : (cyc_r + CNT_BW'(1));

    // Busy-cycle counter; the DONE cycle itself is included in the published count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_r  <= {CNT_BW{1'b0}};
            perf_r <= {CNT_BW{1'b0}};
        end else begin
            if (accept_s) begin
                cyc_r <= {CNT_BW{1'b0}};
            end else if (busy_s) begin
                cyc_r <= cyc_inc_s;
            end
            if (done_s) begin
                perf_r <= cyc_inc_s;
            end
        end
    end

    assign perf_cyc_o = perf_r;
`else
    assign perf_cyc_o = {CNT_BW{1'b0}};
`endif

    assign cmd_ready = ready_r;
    assign gemm_uno  = uno_r;
    assign wload_o   = wload_s;
    assign feed_en   = feed_s;
    assign beat_idx  = beat_r;
    assign busy_o    = busy_s;
    assign done_o    = done_s;

endmodule

// File: tb/tb_pe_ctrl.sv
// Directed self-checking bench for pe_ctrl with default parameters (ROWS=4, PIPE_LAT=2).
module tb_pe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_len;
    logic        in_valid;
    logic [1:0]  gemm_uno;
    logic        wload_o;
    logic        feed_en;
    logic [15:0] beat_idx;
    logic        busy_o;
    logic        done_o;
    logic [15:0] perf_cyc_o;

    int checks_cnt = 0;
    int errors_cnt = 0;

    pe_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_len    (cmd_len),
        .in_valid   (in_valid),
        .gemm_uno   (gemm_uno),
        .wload_o    (wload_o),
        .feed_en    (feed_en),
        .beat_idx   (beat_idx),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .perf_cyc_o (perf_cyc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command in the current IDLE cycle (k=0) and follow it to done_o.
    // stall bit k drives in_valid low in cycle k after acceptance.
    task automatic run_op(input logic [1:0] op, input logic [15:0] len, input logic [63:0] stall,
                          output int wl, output int fe, output int done_k,
                          output int overlap, output int uno_bad, output int beat_bad,
                          output int final_beat);
        int exp_beat;
        wl = 0; fe = 0; done_k = -1; overlap = 0; uno_bad = 0; beat_bad = 0;
        final_beat = -1; exp_beat = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        in_valid  = ~stall[0];
        #1;
        check_val("accept_ready", {31'd0, cmd_ready}, 32'd1);
        for (int k = 1; k <= 40; k++) begin
            tick();
            cmd_valid = 1'b0;
            in_valid  = ~stall[k];
            #1;
            if (wload_o) wl++;
            if (feed_en) begin
                fe++;
                if (beat_idx != 16'(exp_beat)) beat_bad++;
                exp_beat++;
            end
            if (wload_o && feed_en) overlap++;
            if (gemm_uno != op) uno_bad++;
            if (done_o) begin
                done_k     = k;
                final_beat = int'(beat_idx);
                break;
            end
        end
    endtask

    int wl, fe, dk, ov, ub, bb, fb;
    int rdy_early, uno_early, done_seen;
    logic [15:0] perf_exp;

    initial begin
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = 16'd0;
        in_valid  = 1'b0;
        #1 rst_n  = 1'b0;
        #2;
        check_val("rst_busy",  {31'd0, busy_o},    32'd0);
        check_val("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check_val("rst_done",  {31'd0, done_o},    32'd0);
        check_val("rst_uno",   {30'd0, gemm_uno},  32'd0);
        check_val("rst_perf",  {16'd0, perf_cyc_o}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check_val("ready_before_edge", {31'd0, cmd_ready}, 32'd0);
        tick();
        check_val("ready_after_edge", {31'd0, cmd_ready}, 32'd1);

        // gemm, len=3, continuous in_valid
        run_op(2'b00, 16'd3, 64'd0, wl, fe, dk, ov, ub, bb, fb);
        check_val("gemm_wload_cycles", wl, 32'd4);
        check_val("gemm_feed_cycles",  fe, 32'd3);
        check_val("gemm_done_at",      dk, 32'd10);
        check_val("gemm_overlap",      ov, 32'd0);
        check_val("gemm_beat_seq",     bb, 32'd0);
        check_val("gemm_final_beat",   fb, 32'd3);
        tick();
`ifdef PE_CTRL_PERF_EN
        perf_exp = 16'd10;
`else
        perf_exp = 16'd0;
`endif
        check_val("gemm_perf", {16'd0, perf_cyc_o}, {16'd0, perf_exp});
        check_val("gemm_idle_ready", {31'd0, cmd_ready}, 32'd1);

        // exp, len=4, in_valid low on 2nd and 3rd STREAM cycles
        run_op(2'b10, 16'd4, 64'h000000000000000C, wl, fe, dk, ov, ub, bb, fb);
        check_val("exp_wload_cycles", wl, 32'd0);
        check_val("exp_feed_cycles",  fe, 32'd4);
        check_val("exp_done_at",      dk, 32'd9);
        check_val("exp_uno_stable",   ub, 32'd0);
        check_val("exp_beat_seq",     bb, 32'd0);
        tick();
`ifdef PE_CTRL_PERF_EN
        perf_exp = 16'd9;
`else
        perf_exp = 16'd0;
`endif
        check_val("exp_perf", {16'd0, perf_cyc_o}, {16'd0, perf_exp});

        // div, len=0
        run_op(2'b01, 16'd0, 64'd0, wl, fe, dk, ov, ub, bb, fb);
        check_val("div0_done_at", dk, 32'd1);
        check_val("div0_wload",   wl, 32'd0);
        check_val("div0_feed",    fe, 32'd0);
        tick();

        // gemm len=3 with a log len=1 command held during it
        rdy_early = 0; uno_early = 0; done_seen = -1;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_len = 16'd3; in_valid = 1'b1;
        #1;
        check_val("hold_accept_ready", {31'd0, cmd_ready}, 32'd1);
        for (int k = 1; k <= 11; k++) begin
            tick();
            cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 16'd1;
            #1;
            if (k <= 10 && cmd_ready) rdy_early++;
            if (gemm_uno != 2'b00) uno_early++;
        end
        check_val("hold_no_early_ready", rdy_early, 32'd0);
        check_val("hold_uno_stable",     uno_early, 32'd0);
        check_val("hold_ready_idle",     {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        #1;
        check_val("hold_uno_log", {30'd0, gemm_uno}, 32'd3);
        check_val("hold_busy",    {31'd0, busy_o},   32'd1);
        for (int k = 13; k <= 30; k++) begin
            tick();
            if (done_o) begin
                done_seen = k;
                break;
            end
        end
        check_val("hold_log_done_at", done_seen, 32'd15);
        tick();

        // reset mid-STREAM of a len=8 gemm
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_len = 16'd8; in_valid = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            cmd_valid = 1'b0;
        end
        #1;
        check_val("pre_rst_feed", {31'd0, feed_en}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_val("async_feed",  {31'd0, feed_en},  32'd0);
        check_val("async_busy",  {31'd0, busy_o},   32'd0);
        check_val("async_wload", {31'd0, wload_o},  32'd0);
        check_val("async_beat",  {16'd0, beat_idx}, 32'd0);
        check_val("async_ready", {31'd0, cmd_ready}, 32'd0);
        done_seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done_o) done_seen++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (done_o) done_seen++;
            if (k == 0) check_val("release_ready_low", {31'd0, cmd_ready}, 32'd0);
            tick();
            if (k == 0) check_val("release_ready_high", {31'd0, cmd_ready}, 32'd1);
        end
        check_val("rst_no_done", done_seen, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/pe_ctrl.md
PE_CTRL -- requirements
Module: pe_ctrl

Interface
REQ-001 The block SHALL have parameter ROWS, default 4: PE array rows, which is also the weight-preload cycle count.
REQ-002 The block SHALL have parameter CNT_BW, default 16: width of the beat-length field and the beat counters.
REQ-003 The block SHALL have parameter PIPE_LAT, default 2: PE pipeline drain cycles (scale/offset register plus output register).
REQ-004 clk  in  1: the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1: reset, asynchronous and active-low.
REQ-006 cmd_valid  in  1: a command is offered.
REQ-007 cmd_ready  out  1: the command is accepted on any cycle where cmd_valid and cmd_ready are both 1.
REQ-008 cmd_op  in  2: requested operation; 00 gemm, 01 div, 10 exp, 11 log.
REQ-009 cmd_len  in  CNT_BW: number of input beats to stream.
REQ-010 in_valid  in  1: the upstream operand beat is present this cycle.
REQ-011 gemm_uno  out  2: mode driven to every PE.
REQ-012 wload_o  out  1: weight preload strobe.
REQ-013 feed_en  out  1: an operand beat is consumed this cycle.
REQ-014 beat_idx  out  CNT_BW: index of the current beat.
REQ-015 busy_o  out  1: an operation is in progress.
REQ-016 done_o  out  1: one-cycle completion pulse.
REQ-017 perf_cyc_o  out  CNT_BW: busy-cycle count of the last operation.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, STREAM, DRAIN and DONE.
REQ-019 cmd_ready SHALL be 1 only in IDLE; an accepted command latches cmd_op into gemm_uno and cmd_len into the length register.
REQ-020 gemm_uno SHALL change only on command acceptance and SHALL stay stable until the block next leaves DONE.
REQ-021 On acceptance the FSM SHALL move as follows: cmd_len==0 goes to DONE; op 00 goes to LOAD; any other op goes to STREAM.
REQ-022 LOAD SHALL last exactly ROWS cycles with wload_o=1, then move to STREAM; in_valid is ignored in LOAD.
REQ-023 STREAM: feed_en = in_valid; beat_idx increments on each beat with feed_en=1; in_valid=0 stalls with no state change.
REQ-024 STREAM SHALL exit to DRAIN on the cycle after the beat with beat_idx == len-1 is consumed.
REQ-025 DRAIN SHALL last exactly PIPE_LAT cycles with feed_en=0, then move to DONE.
REQ-026 DONE SHALL last one cycle with done_o=1 and then return to IDLE; a command cannot be accepted in the same cycle as done_o.
REQ-027 busy_o SHALL be 1 in every state except IDLE.
REQ-028 beat_idx SHALL clear to 0 on acceptance and SHALL hold its final value through DRAIN and DONE; it does not wrap, because len is at most 2^CNT_BW-1.
REQ-029 wload_o and feed_en SHALL never be 1 in the same cycle.
REQ-030 cmd_valid while busy SHALL be ignored: the command is neither latched nor dropped, and upstream holds it.

Reset
REQ-031 rst_n=0 SHALL immediately, without a clock, force state IDLE with gemm_uno=00, wload_o=0, feed_en=0, beat_idx=0, busy_o=0, done_o=0, perf_cyc_o=0 and cmd_ready=0.
REQ-032 cmd_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-033 Reset during any state SHALL abort the operation with no done_o pulse.

Configuration
REQ-034 With macro PE_CTRL_PERF_EN defined, a counter SHALL increment on every busy cycle, reset on command acceptance, and copy into perf_cyc_o on DONE, saturating at all-ones.
REQ-035 Without PE_CTRL_PERF_EN, the counter SHALL be absent and perf_cyc_o SHALL be constant 0.

Verification
REQ-036 Gemm, len=3, in_valid=1 continuously, ROWS=4, PIPE_LAT=2 -> wload_o high 4 cycles, feed_en high 3 cycles with beat_idx 0,1,2, 2 drain cycles, done_o 10 cycles after acceptance; perf_cyc_o=10 with PERF_EN.
REQ-037 Exp (op 10), len=4, in_valid low on the 2nd and 3rd STREAM cycles -> no LOAD, feed_en high 4 cycles spread over 6, gemm_uno=10 throughout, done_o 9 cycles after acceptance.
REQ-038 Div (op 01), len=0 -> done_o on the cycle after acceptance, feed_en and wload_o never asserted.
REQ-039 cmd_valid held high with a 2nd command (log, len=1) during a gemm op -> 2nd command accepted only in IDLE after DONE; gemm_uno goes 00 to 11 at that acceptance.
REQ-040 rst_n pulsed low mid-STREAM of a len=8 gemm -> all outputs 0 asynchronously, no done_o, and cmd_ready=1 one cycle after release.
